// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding and bus phase constants
// used by apb_master and apb_slave.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // penable level that distinguishes the two transfer phases while psel is high
  localparam logic PENABLE_SETUP  = 1'b0;
  localparam logic PENABLE_ACCESS = 1'b1;

endpackage

// File: rtl/apb_master.sv
// APB requester: single-beat local commands become SETUP/ACCESS transfers;
// a watchdog aborts transfers whose pready never arrives.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [WIDTH-1:0] paddr,
  output logic [WIDTH-1:0] pwdata,
  input  logic             pready,
  input  logic [WIDTH-1:0] prdata
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  apb_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [WIDTH-1:0] paddr_q, paddr_d;
  logic [WIDTH-1:0] pwdata_q, pwdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = PENABLE_SETUP;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = PENABLE_ACCESS;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        // pready is checked first so it wins on the final watchdog cycle
        if (pready) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (!pwrite_q) rsp_rdata_d = prdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a driver pushes hand-computed expectations,
// a monitor pops and compares on every rsp_valid pulse.
module tb_apb_master;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       pready;
  logic [7:0] prdata;

  apb_master #(.WIDTH(8), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  // slave model: memory, programmable wait states, dead mode, stray pready
  logic [7:0] mem [256];
  int         wait_n = 0;
  int         wcnt = 0;
  logic       dead = 1'b0;
  logic       stray = 1'b0;

  always_comb begin
    pready = stray || (psel && penable && !dead && (wcnt >= wait_n));
    prdata = mem[paddr];
  end

  always @(posedge pclk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] rd;
    logic       err;
    int         acc;
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wd;
  } exp_t;

  exp_t sb[$];

  // monitor state
  int         acc_cnt = 0;
  int         setups = 0;
  logic       stable = 1'b1;
  logic       prev_acc = 1'b0;
  int         viol = 0;
  logic [7:0] s_addr, s_wd;
  logic       s_wr;

  always @(negedge pclk) begin
    if (!presetn) begin
      acc_cnt = 0; setups = 0; stable = 1'b1; prev_acc = 1'b0;
    end else begin
      if (psel && !penable) begin
        if (prev_acc) viol++;
        setups++;
        acc_cnt = 0;
        stable = 1'b1;
        s_addr = paddr; s_wr = pwrite; s_wd = pwdata;
      end
      if (psel && penable) begin
        acc_cnt++;
        if (paddr !== s_addr || pwrite !== s_wr || pwdata !== s_wd) stable = 1'b0;
      end
      if (cmd_ready && psel) viol++;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("access_cycles", 32'(acc_cnt), 32'(e.acc));
          chk("setup_count", 32'(setups), 32'd1);
          chk("paddr", 32'(s_addr), 32'(e.addr));
          chk("pwrite", 32'(s_wr), 32'(e.wr));
          if (e.wr) chk("pwdata", 32'(s_wd), 32'(e.wd));
          chk("access_stable", 32'(stable), 32'd1);
        end
        setups = 0;
      end
      prev_acc = psel && penable;
    end
  end

  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rd, input logic err, input int acc);
    int n;
    exp_t e;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge pclk);
    e.rd = rd; e.err = err; e.acc = acc; e.addr = a; e.wr = wr; e.wd = d;
    sb.push_back(e);
  endtask

  task automatic drop_cmd();
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // reset values
    #12;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", 32'(pwdata), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge pclk);
    presetn = 1'b1;

    // write then read-back, zero wait states
    issue(1'b1, 8'd3, 8'hA5, 8'h00, 1'b0, 1);
    drop_cmd();
    drain();
    chk("mem3_after_write", 32'(mem[3]), 32'hA5);
    issue(1'b0, 8'd3, 8'h00, 8'hA5, 1'b0, 1);
    drop_cmd();
    drain();

    // five wait states
    wait_n = 5;
    issue(1'b1, 8'd10, 8'h3C, 8'hA5, 1'b0, 6);
    drop_cmd();
    drain();
    issue(1'b0, 8'd10, 8'h00, 8'h3C, 1'b0, 6);
    drop_cmd();
    drain();

    // watchdog abort: 16 ACCESS cycles, rdata cleared
    dead = 1'b1;
    issue(1'b0, 8'd3, 8'h00, 8'h00, 1'b0 | 1'b1, 16);
    drop_cmd();
    drain();
    chk("idle_after_timeout", 32'(cmd_ready), 32'd1);

    // pready arriving on the last watchdog cycle completes normally
    dead = 1'b0;
    wait_n = 15;
    issue(1'b0, 8'd10, 8'h00, 8'h3C, 1'b0, 16);
    drop_cmd();
    drain();

    // back-to-back writes with cmd_valid held high
    wait_n = 0;
    for (int i = 0; i < 8; i++) issue(1'b1, 8'(i), 8'h50 + 8'(i), 8'h3C, 1'b0, 1);
    drop_cmd();
    drain();
    chk("mem0_b2b", 32'(mem[0]), 32'h50);
    issue(1'b0, 8'd7, 8'h00, 8'h57, 1'b0, 1);
    drop_cmd();
    drain();

    // stray pready while idle must not produce a response
    stray = 1'b1;
    repeat (5) @(negedge pclk);
    stray = 1'b0;
    repeat (3) @(negedge pclk);

    // reset during ACCESS
    dead = 1'b1;
    issue(1'b0, 8'd3, 8'h00, 8'h00, 1'b0, 1);
    drop_cmd();
    n = 0;
    while (!penable && n < 50) begin
      @(negedge pclk);
      n++;
    end
    chk("reached_access", 32'(penable), 32'd1);
    repeat (3) @(negedge pclk);
    void'(sb.pop_back());
    #1 presetn = 1'b0;
    #1;
    chk("async_rst_psel", 32'(psel), 32'd0);
    chk("async_rst_penable", 32'(penable), 32'd0);
    dead = 1'b0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    repeat (4) @(negedge pclk);
    chk("post_rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("post_rst_rdata", 32'(rsp_rdata), 32'd0);
    issue(1'b1, 8'd20, 8'hC3, 8'h00, 1'b0, 1);
    drop_cmd();
    drain();
    issue(1'b0, 8'd20, 8'h00, 8'hC3, 1'b0, 1);
    drop_cmd();
    drain();

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
